// File: rtl/demux_route_if.sv
// Stream bundle for demux_route: one upstream port and two routed
// downstream ports (A and B).
//   in_valid/in_ready/in_data : upstream word handshake
//   sel_b1/sel_b2             : route select terms (B when both set)
//   out_a_* / out_b_*         : downstream stream ports
// Modports: slave = the router, master = whatever drives/observes it.
interface demux_route_if #(
  parameter int unsigned DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              sel_b1;
  logic              sel_b2;
  logic              out_a_valid;
  logic              out_a_ready;
  logic [DATA_W-1:0] out_a_data;
  logic              out_b_valid;
  logic              out_b_ready;
  logic [DATA_W-1:0] out_b_data;

  modport slave (
    input  in_valid, in_data, sel_b1, sel_b2, out_a_ready, out_b_ready,
    output in_ready, out_a_valid, out_a_data, out_b_valid, out_b_data
  );

  modport master (
    output in_valid, in_data, sel_b1, sel_b2, out_a_ready, out_b_ready,
    input  in_ready, out_a_valid, out_a_data, out_b_valid, out_b_data
  );
endinterface

// File: rtl/demux_route.sv
// demux_route: routes each upstream word to port B when sel_b1 & sel_b2,
// otherwise to port A. Each port owns a single-entry slot (EMPTY/FULL)
// that supports simultaneous drain and reload for 1 word/cycle/port.
// Ports:
//   clk       : clock, rising edge
//   areset_n  : asynchronous active-low reset
//   bus       : demux_route_if.slave stream bundle
//   cnt_a/b   : 8-bit wrapping delivered-word counters, present only when
//               DEMUX_ROUTE_CNT_EN is defined
// in_ready is combinational from the select terms and downstream readies.
module demux_route #(
  parameter int unsigned DATA_W = 8
) (
  input  logic                clk,
  input  logic                areset_n,
  demux_route_if.slave        bus
`ifdef DEMUX_ROUTE_CNT_EN
  ,
  output logic [7:0]          cnt_a,
  output logic [7:0]          cnt_b
`endif
);

  localparam int unsigned CNT_W = 8;

  localparam logic [0:0] SLOT_EMPTY = 1'b0;
  localparam logic [0:0] SLOT_FULL  = 1'b1;

  logic [0:0]        state_a_q, state_a_d;
  logic [0:0]        state_b_q, state_b_d;
  logic [DATA_W-1:0] data_a_q,  data_a_d;
  logic [DATA_W-1:0] data_b_q,  data_b_d;

  logic dest_b_c;
  logic in_ready_c;
  logic load_a_c, load_b_c;
  logic drain_a_c, drain_b_c;

  // Handshake decode; a slot can take a word if empty or draining this cycle
  always_comb begin
    dest_b_c   = bus.sel_b1 & bus.sel_b2;
    drain_a_c  = (state_a_q == SLOT_FULL) & bus.out_a_ready;
    drain_b_c  = (state_b_q == SLOT_FULL) & bus.out_b_ready;
    in_ready_c = dest_b_c ? ((state_b_q == SLOT_EMPTY) | bus.out_b_ready)
                          : ((state_a_q == SLOT_EMPTY) | bus.out_a_ready);
    load_a_c   = bus.in_valid & in_ready_c & ~dest_b_c;
    load_b_c   = bus.in_valid & in_ready_c &  dest_b_c;
  end

  // Slot next-state: load wins over drain so a same-cycle refill stays FULL
  always_comb begin
    state_a_d = state_a_q;
    state_b_d = state_b_q;
    data_a_d  = data_a_q;
    data_b_d  = data_b_q;

    case (state_a_q)
      SLOT_EMPTY: if (load_a_c) state_a_d = SLOT_FULL;
      SLOT_FULL:  if (!load_a_c && drain_a_c) state_a_d = SLOT_EMPTY;
      default:    state_a_d = SLOT_EMPTY;
    endcase
    if (load_a_c) data_a_d = bus.in_data;

    case (state_b_q)
      SLOT_EMPTY: if (load_b_c) state_b_d = SLOT_FULL;
      SLOT_FULL:  if (!load_b_c && drain_b_c) state_b_d = SLOT_EMPTY;
      default:    state_b_d = SLOT_EMPTY;
    endcase
    if (load_b_c) data_b_d = bus.in_data;
  end

  // Slot state and payload registers; EMPTY slots keep their last payload
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_a_q <= SLOT_EMPTY;
      state_b_q <= SLOT_EMPTY;
      data_a_q  <= '0;
      data_b_q  <= '0;
    end else begin
      state_a_q <= state_a_d;
      state_b_q <= state_b_d;
      data_a_q  <= data_a_d;
      data_b_q  <= data_b_d;
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_a_valid = (state_a_q == SLOT_FULL);
  assign bus.out_a_data  = data_a_q;
  assign bus.out_b_valid = (state_b_q == SLOT_FULL);
  assign bus.out_b_data  = data_b_q;

`ifdef DEMUX_ROUTE_CNT_EN
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

  // Delivered-word counters, free-running wrap
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (drain_a_c) cnt_a_d = cnt_a_q + CNT_W'(1);
    if (drain_b_c) cnt_b_d = cnt_b_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_demux_route.sv
// Directed + randomized bench for demux_route. Per-port queues hold the
// words accepted but not yet delivered; the head of each queue is what the
// port must present. Counter checks apply when DEMUX_ROUTE_CNT_EN is set.
module tb_demux_route;

  localparam int unsigned DATA_W = 8;

  logic clk;
  logic areset_n;

  demux_route_if #(.DATA_W(DATA_W)) bus ();

`ifdef DEMUX_ROUTE_CNT_EN
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;
  demux_route #(.DATA_W(DATA_W)) dut (
    .clk(clk), .areset_n(areset_n), .bus(bus), .cnt_a(cnt_a), .cnt_b(cnt_b)
  );
`else
  demux_route #(.DATA_W(DATA_W)) dut (
    .clk(clk), .areset_n(areset_n), .bus(bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] exp_a[$];
  logic [DATA_W-1:0] exp_b[$];
  logic [7:0]        mcnt_a = 8'd0;
  logic [7:0]        mcnt_b = 8'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at negedge against the queues, then apply the
  // edge (drain before load), and return just after the rising edge.
  task automatic step();
    logic exp_rdy;
    logic dest_b;
    @(negedge clk);
    dest_b  = bus.sel_b1 & bus.sel_b2;
    exp_rdy = dest_b ? (exp_b.size() == 0 || bus.out_b_ready)
                     : (exp_a.size() == 0 || bus.out_a_ready);
    chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    chk("a_valid", 64'(bus.out_a_valid), 64'(exp_a.size() != 0));
    chk("b_valid", 64'(bus.out_b_valid), 64'(exp_b.size() != 0));
    if (exp_a.size() != 0) chk("a_data", 64'(bus.out_a_data), 64'(exp_a[0]));
    if (exp_b.size() != 0) chk("b_data", 64'(bus.out_b_data), 64'(exp_b[0]));
`ifdef DEMUX_ROUTE_CNT_EN
    chk("cnt_a", 64'(cnt_a), 64'(mcnt_a));
    chk("cnt_b", 64'(cnt_b), 64'(mcnt_b));
`endif
    if (exp_a.size() != 0 && bus.out_a_ready) begin
      void'(exp_a.pop_front());
      mcnt_a = mcnt_a + 8'd1;
    end
    if (exp_b.size() != 0 && bus.out_b_ready) begin
      void'(exp_b.pop_front());
      mcnt_b = mcnt_b + 8'd1;
    end
    if (bus.in_valid && exp_rdy) begin
      if (dest_b) exp_b.push_back(bus.in_data);
      else        exp_a.push_back(bus.in_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d,
                       input logic s1, input logic s2);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.sel_b1   = s1;
    bus.sel_b2   = s2;
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    #1;
    chk("rst_a_valid", 64'(bus.out_a_valid), 64'd0);
    chk("rst_b_valid", 64'(bus.out_b_valid), 64'd0);
    chk("rst_a_data", 64'(bus.out_a_data), 64'd0);
    chk("rst_b_data", 64'(bus.out_b_data), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef DEMUX_ROUTE_CNT_EN
    chk("rst_cnt_a", 64'(cnt_a), 64'd0);
    chk("rst_cnt_b", 64'(cnt_b), 64'd0);
`endif
    exp_a.delete();
    exp_b.delete();
    mcnt_a = 8'd0;
    mcnt_b = 8'd0;
    @(negedge clk);
    areset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    bus.out_a_ready = 1'b0;
    bus.out_b_ready = 1'b0;
    areset_n = 1'b1;
    #2;
    do_reset();

    // Single word to A (only one select term set)
    bus.out_a_ready = 1'b1;
    drive(1'b1, 8'h5A, 1'b1, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("req28_a_valid", 64'(bus.out_a_valid), 64'd1);
    chk("req28_a_data", 64'(bus.out_a_data), 64'h5A);
    chk("req28_b_valid", 64'(bus.out_b_valid), 64'd0);
    step();

    // B stalled: second word back-pressured until B drains
    bus.out_b_ready = 1'b0;
    drive(1'b1, 8'h11, 1'b1, 1'b1);
    step();
    drive(1'b1, 8'h22, 1'b1, 1'b1);
    step();
    chk("req29_held_data", 64'(bus.out_b_data), 64'h11);
    chk("req29_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    bus.out_b_ready = 1'b1;
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("req29_next_data", 64'(bus.out_b_data), 64'h22);
    step();
    step();

    // Back-to-back alternating A/B with both ports ready
    bus.out_a_ready = 1'b1;
    bus.out_b_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DATA_W'(i), (i % 2) == 0, (i % 2) == 0);
      step();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    step();

    // A stalled full, word for B passes through
    bus.out_a_ready = 1'b0;
    drive(1'b1, 8'h33, 1'b0, 1'b1);
    step();
    drive(1'b1, 8'h44, 1'b1, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("req31_b_data", 64'(bus.out_b_data), 64'h44);
    chk("req31_a_data", 64'(bus.out_a_data), 64'h33);
    step();

    // Fill both slots, then reset mid-operation
    bus.out_b_ready = 1'b0;
    drive(1'b1, 8'h77, 1'b1, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("req32_a_full", 64'(bus.out_a_valid), 64'd1);
    chk("req32_b_full", 64'(bus.out_b_valid), 64'd1);
    do_reset();
    step();

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      bus.out_a_ready = 1'($urandom_range(0, 3) != 0);
      bus.out_b_ready = 1'($urandom_range(0, 3) != 0);
      drive(1'($urandom_range(0, 1)), DATA_W'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    bus.out_a_ready = 1'b1;
    bus.out_b_ready = 1'b1;
    step();
    step();

`ifdef DEMUX_ROUTE_CNT_EN
    // 257 words to A: counter wraps to 1
    do_reset();
    bus.out_a_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      drive(1'b1, DATA_W'(i), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    chk("req33_cnt_a", 64'(cnt_a), 64'd1);
    chk("req33_cnt_b", 64'(cnt_b), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_route.md
DEMUX_ROUTE -- requirements
Module: demux_route

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, payload width in bits (legal range 1..64).
REQ-002 SHALL provide clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide areset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL provide in_valid  input  1  upstream word present.
REQ-005 SHALL provide in_ready  output  1  block accepts the word this cycle.
REQ-006 SHALL provide in_data  input  DATA_W  upstream payload.
REQ-007 SHALL provide sel_b1  input  1  route select term 1, qualified by in_valid.
REQ-008 SHALL provide sel_b2  input  1  route select term 2, qualified by in_valid.
REQ-009 SHALL provide out_a_valid / out_a_ready / out_a_data  output / input / output  1 / 1 / DATA_W  port A stream.
REQ-010 SHALL provide out_b_valid / out_b_ready / out_b_data  output / input / output  1 / 1 / DATA_W  port B stream.
REQ-011 SHALL provide cnt_a, cnt_b  output  8 each  delivered-word counters (present only per REQ-027).

Function
REQ-012 SHALL route each word to port B when sel_b1 & sel_b2 is 1, otherwise to port A.
REQ-013 SHALL hold one single-entry slot per output port, each with states EMPTY and FULL.
REQ-014 SHALL drive out_x_valid high exactly when slot x is FULL; out_x_data = slot contents.
REQ-015 SHALL drive in_ready = slot[dest] EMPTY, or slot[dest] FULL with out_dest_ready = 1; combinational, never dependent on in_valid.
REQ-016 SHALL accept a word when in_valid & in_ready: load slot[dest] at the next edge; latency in-accept to out_x_valid = 1 cycle.
REQ-017 SHALL transition slot x FULL->EMPTY on out_x_valid & out_x_ready with no load to x that cycle.
REQ-018 SHALL, on simultaneous drain and load of the same slot, stay FULL with the new word (full throughput, 1 word/cycle per port).
REQ-019 SHALL let the non-destination slot drain independently in the same cycle as a load to the other slot.
REQ-020 SHALL hold out_x_data and out_x_valid stable while out_x_valid & !out_x_ready.
REQ-021 SHALL retain the last payload in an EMPTY slot's data register (no clearing except reset).
REQ-022 SHALL preserve ordering per port; no ordering guarantee across ports.
REQ-023 SHALL increment cnt_x by 1 on each out_x handshake, wrapping 255 -> 0; never saturate.

Reset
REQ-024 SHALL, on areset_n low, immediately force both slots EMPTY, out_a_valid = out_b_valid = 0, out_a_data = out_b_data = 0, cnt_a = cnt_b = 0.
REQ-025 SHALL discard buffered words when reset asserts mid-operation; no partial transfer completes.
REQ-026 SHALL present in_ready = 1 while in reset and on the first cycle after release (slots EMPTY).

Configuration
REQ-027 SHALL compile cnt_a, cnt_b and their logic only when DEMUX_ROUTE_CNT_EN is defined; without it, these ports and counters SHALL be absent and all other behaviour unchanged.

Verification
REQ-028 SHALL cover: reset, in_data=0x5A, sel_b1=1, sel_b2=0, out_a_ready=1 -> next cycle out_a_valid=1, out_a_data=0x5A, out_b_valid=0.
REQ-029 SHALL cover: sel_b1=sel_b2=1, out_b_ready=0, two words 0x11, 0x22 -> 0x11 held on B, in_ready=0 for second word until out_b_ready=1, then 0x22 follows next cycle.
REQ-030 SHALL cover: both ports ready, back-to-back 0x01..0x08 alternating A/B select -> one word accepted per cycle, in_ready never 0, per-port order preserved.
REQ-031 SHALL cover: port A FULL stalled, word destined to B -> in_ready=1, word on B one cycle later while A data stays unchanged.
REQ-032 SHALL cover: areset_n low while both slots FULL -> both out_x_valid=0 and data=0 immediately, no handshake recorded.
REQ-033 SHALL cover (DEMUX_ROUTE_CNT_EN defined): 257 words to A with out_a_ready=1 -> cnt_a=1, cnt_b=0.
